spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
//  SPI responder (slave) that sits at the far end of a spi_master link and runs entirely in the clkIn domain.
//  SCLK, CS_n and MOSI are oversampled through synchronizers. MSB-first words are shifted in on MOSI and out on MISO.
//  A received word is presented with a one-cycle valid strobe. The next transmit word is accepted through a valid/ready handshake.
//  Requires SYSTEM_CLK_FREQ >= 8 * SCLK frequency.
// PARAMETERS
//  CPOL            1'b1   idle level of SCLK
//  CPHA            1'b1   0: sample on leading edge; 1: sample on trailing edge
//  SPI_DATA_WIDTH  8      bits per word, >= 2
//  DEFAULT_TX      {SPI_DATA_WIDTH{1'b1}}  word shifted out when no tx word is loaded
// PORTS
//  clkIn          in   1                system clock; the only clock
//  rstIn          in   1                synchronous, active-high reset
//  txDataIn       in   SPI_DATA_WIDTH   next word to return to master
//  txValidIn      in   1                txDataIn valid
//  txReadyOut     out  1                tx holding register empty; txDataIn accepted when txValidIn & txReadyOut
//  rxDataOut      out  SPI_DATA_WIDTH   last complete word from MOSI
//  rxValidOut     out  1                1-cycle strobe: rxDataOut updated
//  txUnderrunOut  out  1                1-cycle strobe: word started with empty holding reg (DEFAULT_TX sent)
//  frameAbortOut  out  1                1-cycle strobe: CS_n rose with partial word
//  spiClkIn       in   1                SCLK from master (asynchronous)
//  spiCsLowIn     in   1                chip select, active low (asynchronous)
//  spiMosiIn      in   1                MOSI (asynchronous)
//  spiMisoOut     out  1                MISO data
//  spiMisoOeOut   out  1                MISO output enable (high only while CS_n synced low)
// BEHAVIOUR
//  - Reset: txReadyOut=1, rxDataOut=0, rxValidOut=0, txUnderrunOut=0, frameAbortOut=0,
//    spiMisoOut=DEFAULT_TX[MSB], spiMisoOeOut=0, bit counter=0, holding reg empty. Reset mid-frame discards the frame.
//  - Inputs pass through 2 flops, then a 3rd flop for edge detection. Leading edge = first SCLK edge away from CPOL.
//    sampleEdge = CPHA ? trailing : leading; shiftEdge = the other edge.
//  - States: IDLE (CS high), ACTIVE (CS low, counting bits), DONE (1 cycle, word complete).
//  - IDLE->ACTIVE on synced CS fall. Load the shift-out reg from the holding reg (mark it empty; txReadyOut=1 next cycle).
//    If the holding reg is empty, load DEFAULT_TX and pulse txUnderrunOut. Drive MSB on MISO at once; this is required for CPHA=0.
//  - CPHA=1: the first shiftEdge of a word presents the MSB (no shift). Each later shiftEdge shifts out the next bit.
//    CPHA=0: each shiftEdge shifts out the next bit.
//  - On each sampleEdge, shift spiMosiIn into the rx shift reg and increment the bit counter.
//  - When the counter reaches SPI_DATA_WIDTH: rxDataOut <= shift reg, with rxValidOut high one cycle later (DONE).
//    That is 4 clkIn after the real SCLK edge. Counter wraps to 0.
//  - Back-to-back words (CS held low): at word completion, reload the shift-out reg from the holding reg or DEFAULT_TX, same rules as the first word.
//  - CS rise in ACTIVE with counter != 0: pulse frameAbortOut, drop the partial word, no rxValidOut, counter=0, go IDLE.
//    CS rise with counter == 0: go IDLE silently.
//  - A tx handshake in the same cycle as a shift-out reload: the reload takes the old holding contents (or DEFAULT_TX if empty).
//    The new word fills the holding reg; there is no loss.
//  - txDataIn is ignored while txReadyOut=0. Sampled SCLK edges while CS is high are ignored.
// STRUCTURE
//  - spi_defs.vh (shared with spi_master): SPI mode localparams (MODE0..MODE3 as {CPOL,CPHA}).
//    Also a function clog2 for the counter width $clog2(SPI_DATA_WIDTH+1).
//  - Sub-module spi_sync_edge: 2-FF synchronizer + edge register; outputs level, rise and fall pulses.
//    Instantiate 3 times (SCLK, CS_n, MOSI; MOSI uses the level only).
//  - Top: state register, bit counter, rx/tx shift regs, tx holding reg + flag.
// TESTING
//  - Mode 3, 8 bits, txDataIn=8'hA5 loaded before CS; master sends 8'h3C.
//    -> MISO bits 1,0,1,0,0,1,0,1; rxDataOut=8'h3C with a single rxValidOut pulse; txReadyOut high after CS fall.
//  - Mode 0, no tx word loaded; master sends 8'h81.
//    -> txUnderrunOut pulse at CS fall, MISO=8'hFF, rxDataOut=8'h81.
//  - Two words under one CS low, 8'h12 then 8'h34 queued via the handshake during word 1.
//    -> two rxValidOut pulses, MISO returns 8'h12 then 8'h34, no underrun.
//  - CS raised after 5 SCLK bits.
//    -> frameAbortOut pulse, no rxValidOut; next full frame 8'hF0 received correctly.
//  - rstIn asserted mid-word (bit 3).
//    -> all outputs at reset values next cycle; following frame 8'h55 received intact.
//  - All four modes with SCLK = clkIn/8, random data: rx matches MOSI and MISO matches queued tx.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared SPI definitions: mode encodings, the responder state type and a width helper.
// The mode encoding is {CPOL, CPHA}, the same encoding spi_master uses.
package spi_slave_pkg;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DONE
  } state_e;

  // Number of bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous input, plus a third flop that
// turns level changes into single-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;

  // Reset to the line's idle level so leaving reset never fakes an edge.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sync_q <= {3{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[1:0], async_i};
    end
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~sync_q[2];
  assign fall_o  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_slave.sv
// SPI responder running entirely in the clkIn domain: oversampled SCLK/CS_n/MOSI,
// MSB-first shift in/out, one-deep tx holding register with valid/ready handshake.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter logic                      CPOL           = 1'b1,
  parameter logic                      CPHA           = 1'b1,
  parameter int                        SPI_DATA_WIDTH = 8,
  parameter logic [SPI_DATA_WIDTH-1:0] DEFAULT_TX     = {SPI_DATA_WIDTH{1'b1}}
) (
  input  logic                      clkIn,
  input  logic                      rstIn,
  input  logic [SPI_DATA_WIDTH-1:0] txDataIn,
  input  logic                      txValidIn,
  output logic                      txReadyOut,
  output logic [SPI_DATA_WIDTH-1:0] rxDataOut,
  output logic                      rxValidOut,
  output logic                      txUnderrunOut,
  output logic                      frameAbortOut,
  input  logic                      spiClkIn,
  input  logic                      spiCsLowIn,
  input  logic                      spiMosiIn,
  output logic                      spiMisoOut,
  output logic                      spiMisoOeOut
);

  localparam int         W    = SPI_DATA_WIDTH;
  localparam int         CW   = clog2(W + 1);
  localparam logic [1:0] MODE = {CPOL, CPHA};

  // Modes 0 and 3 sample on rising SCLK; modes 1 and 2 shift on rising SCLK.
  localparam logic SAMPLE_ON_RISE = (MODE == MODE0) || (MODE == MODE3);
  localparam logic SHIFT_ON_RISE  = (MODE == MODE1) || (MODE == MODE2);

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise, mosi_fall;
  logic unused_mosi_edges;

  spi_sync_edge #(.RESET_VAL(CPOL)) u_sync_sclk (
    .clk_i(clkIn), .srst_i(rstIn), .async_i(spiClkIn),
    .level_o(sclk_level), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk_i(clkIn), .srst_i(rstIn), .async_i(spiCsLowIn),
    .level_o(cs_level), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i(clkIn), .srst_i(rstIn), .async_i(spiMosiIn),
    .level_o(mosi_level), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  assign unused_mosi_edges = ^{mosi_rise, mosi_fall, sclk_level};

  state_e         state_q;
  logic [CW-1:0]  bit_cnt_q;
  logic [W-1:0]   rx_shift_q;
  logic [W-1:0]   tx_shift_q;
  logic [W-1:0]   hold_q;
  logic           hold_full_q;
  logic [W-1:0]   rx_data_q;
  logic           rx_valid_q;
  logic           underrun_q;
  logic           underrun_pend_q;
  logic           abort_q;

  logic           lead_edge, sample_edge, shift_edge;
  logic           word_done, reload, tx_accept;
  logic [W-1:0]   rx_shift_d;

  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign sample_edge = SAMPLE_ON_RISE ? sclk_rise : sclk_fall;
  assign shift_edge  = SHIFT_ON_RISE ? sclk_rise : sclk_fall;
  assign rx_shift_d  = {rx_shift_q[W-2:0], mosi_level};

  assign word_done = (state_q == ST_ACTIVE) && !cs_rise && sample_edge
                     && (bit_cnt_q == CW'(W - 1));
  assign reload    = ((state_q == ST_IDLE) && cs_fall) || word_done;
  assign tx_accept = txValidIn && !hold_full_q;

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state_q         <= ST_IDLE;
      bit_cnt_q       <= '0;
      rx_shift_q      <= '0;
      tx_shift_q      <= DEFAULT_TX;
      hold_q          <= '0;
      hold_full_q     <= 1'b0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      underrun_q      <= 1'b0;
      underrun_pend_q <= 1'b0;
      abort_q         <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_q         <= ST_ACTIVE;
            bit_cnt_q       <= '0;
            underrun_pend_q <= 1'b0;
            underrun_q      <= !hold_full_q;
          end
        end

        ST_ACTIVE: begin
          if (cs_rise) begin
            abort_q         <= (bit_cnt_q != '0);
            bit_cnt_q       <= '0;
            underrun_pend_q <= 1'b0;
            state_q         <= ST_IDLE;
          end else begin
            // A mid-frame reload from an empty holding register only counts as an
            // underrun once the master actually clocks the next word.
            if (lead_edge && (bit_cnt_q == '0) && underrun_pend_q) begin
              underrun_q      <= 1'b1;
              underrun_pend_q <= 1'b0;
            end
            // Shift edges at count 0 only present the MSB that is already on MISO.
            if (shift_edge && (bit_cnt_q != '0)) begin
              tx_shift_q <= {tx_shift_q[W-2:0], 1'b1};
            end
            if (sample_edge) begin
              rx_shift_q <= rx_shift_d;
              if (word_done) begin
                bit_cnt_q       <= '0;
                rx_data_q       <= rx_shift_d;
                underrun_pend_q <= !hold_full_q;
                state_q         <= ST_DONE;
              end else begin
                bit_cnt_q <= bit_cnt_q + CW'(1);
              end
            end
          end
        end

        ST_DONE: begin
          rx_valid_q <= 1'b1;
          state_q    <= cs_rise ? ST_IDLE : ST_ACTIVE;
        end

        default: state_q <= ST_IDLE;
      endcase

      if (reload) begin
        tx_shift_q <= hold_full_q ? hold_q : DEFAULT_TX;
      end

      // Reload reads the old holding contents, so a same-cycle handshake is never lost.
      if (tx_accept) begin
        hold_q      <= txDataIn;
        hold_full_q <= 1'b1;
      end else if (reload) begin
        hold_full_q <= 1'b0;
      end
    end
  end

  assign txReadyOut    = !hold_full_q;
  assign rxDataOut     = rx_data_q;
  assign rxValidOut    = rx_valid_q;
  assign txUnderrunOut = underrun_q;
  assign frameAbortOut = abort_q;
  assign spiMisoOut    = tx_shift_q[W-1];
  assign spiMisoOeOut  = !cs_level;

endmodule

// File: tb/tb_spi_slave.sv
// Randomized self-checking bench for spi_slave: one instance per SPI mode, driven
// by a bit-level master and checked against a word-level transfer model.
module tb_spi_slave;

  logic       clk;
  logic       rst;
  logic       sclk     [4];
  logic       cs_n     [4];
  logic       mosi;
  logic [7:0] tx_data;
  logic       tx_valid [4];
  logic       tx_ready [4];
  logic [7:0] rx_data  [4];
  logic       rx_valid [4];
  logic       underrun [4];
  logic       abort_s  [4];
  logic       miso     [4];
  logic       miso_oe  [4];

  int checks;
  int errors;
  int cur;
  int under_cnt;
  int abort_cnt;
  logic [7:0] rx_q[$];

  logic [7:0] mosi_w  [4];
  logic [7:0] txw     [4];
  bit         push_en [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      spi_slave #(
        .CPOL          ((gi / 2) == 1),
        .CPHA          ((gi % 2) == 1),
        .SPI_DATA_WIDTH(8),
        .DEFAULT_TX    (8'hFF)
      ) u_dut (
        .clkIn        (clk),
        .rstIn        (rst),
        .txDataIn     (tx_data),
        .txValidIn    (tx_valid[gi]),
        .txReadyOut   (tx_ready[gi]),
        .rxDataOut    (rx_data[gi]),
        .rxValidOut   (rx_valid[gi]),
        .txUnderrunOut(underrun[gi]),
        .frameAbortOut(abort_s[gi]),
        .spiClkIn     (sclk[gi]),
        .spiCsLowIn   (cs_n[gi]),
        .spiMosiIn    (mosi),
        .spiMisoOut   (miso[gi]),
        .spiMisoOeOut (miso_oe[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe monitor for the instance currently under test.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid[cur]) rx_q.push_back(rx_data[cur]);
      if (underrun[cur]) under_cnt++;
      if (abort_s[cur])  abort_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Handshake one word into the holding register; takes exactly one clkIn period.
  task automatic push_tx(input int m, input logic [7:0] w);
    check_eq("tx_ready_before_push", 32'(tx_ready[m]), 32'd1);
    tx_data     = w;
    tx_valid[m] = 1'b1;
    #10;
    tx_valid[m] = 1'b0;
  endtask

  task automatic half_bit(input int m, input bit do_push, input logic [7:0] pw);
    if (do_push) begin
      push_tx(m, pw);
      #30;
    end else begin
      #40;
    end
  endtask

  // Master side of one word: SCLK = clkIn/8, MISO sampled on the sample edge.
  task automatic xfer_word(input int m, input logic [7:0] mo, input int nbits,
                           input bit do_push, input logic [7:0] pw, output logic [7:0] mi);
    bit cpol;
    bit cpha;
    int i;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    mi = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      i = 7 - k;
      if (!cpha) begin
        mosi = mo[i];
        #40;
        mi[i] = miso[m];
        sclk[m] = ~cpol;
        half_bit(m, do_push && (k == 0), pw);
        sclk[m] = cpol;
      end else begin
        sclk[m] = ~cpol;
        mosi = mo[i];
        #40;
        mi[i] = miso[m];
        sclk[m] = cpol;
        half_bit(m, do_push && (k == 0), pw);
      end
    end
  endtask

  // One CS-low frame of nw words (or a partial word when abort_bits > 0).
  task automatic run_frame(input int m, input int nw, input int abort_bits,
                           input bit pre, input logic [7:0] pre_w);
    logic [7:0] exp_miso [4];
    logic [7:0] holding;
    logic [7:0] got;
    bit hold_full;
    int exp_under;
    bit do_push;
    cur = m;
    @(negedge clk);
    rx_q.delete();
    under_cnt = 0;
    abort_cnt = 0;
    hold_full = 1'b0;
    holding   = 8'h00;
    exp_under = 0;
    if (pre) begin
      push_tx(m, pre_w);
      check_eq("tx_ready_full", 32'(tx_ready[m]), 32'd0);
      holding   = pre_w;
      hold_full = 1'b1;
    end
    cs_n[m] = 1'b0;
    #80;
    exp_miso[0] = hold_full ? holding : 8'hFF;
    if (!hold_full) exp_under++;
    hold_full = 1'b0;
    check_eq("tx_ready_after_cs", 32'(tx_ready[m]), 32'd1);
    check_eq("miso_oe_active", 32'(miso_oe[m]), 32'd1);
    for (int w = 0; w < nw; w++) begin
      do_push = push_en[w] && (w < nw - 1);
      xfer_word(m, mosi_w[w], (abort_bits > 0) ? abort_bits : 8, do_push, txw[w], got);
      if (do_push) begin
        holding   = txw[w];
        hold_full = 1'b1;
      end
      if (w < nw - 1) begin
        exp_miso[w+1] = hold_full ? holding : 8'hFF;
        if (!hold_full) exp_under++;
        hold_full = 1'b0;
      end
      if (abort_bits == 0) check_eq("miso_word", 32'(got), 32'(exp_miso[w]));
    end
    #40;
    cs_n[m] = 1'b1;
    #100;
    check_eq("rx_word_count", rx_q.size(), (abort_bits > 0) ? 0 : nw);
    if (abort_bits == 0) begin
      for (int w = 0; w < nw && w < rx_q.size(); w++) begin
        check_eq("rx_word", 32'(rx_q[w]), 32'(mosi_w[w]));
      end
    end
    check_eq("underrun_count", under_cnt, exp_under);
    check_eq("abort_count", abort_cnt, (abort_bits > 0) ? 1 : 0);
    check_eq("miso_oe_idle", 32'(miso_oe[m]), 32'd0);
    $display("frame mode=%0d words=%0d abort_bits=%0d rx_words=%0d underruns=%0d",
             m, nw, abort_bits, rx_q.size(), under_cnt);
  endtask

  initial begin
    logic [7:0] dummy;
    checks    = 0;
    errors    = 0;
    cur       = 0;
    under_cnt = 0;
    abort_cnt = 0;
    rst       = 1'b1;
    mosi      = 1'b0;
    tx_data   = 8'h00;
    for (int m = 0; m < 4; m++) begin
      sclk[m]     = (m >= 2);
      cs_n[m]     = 1'b1;
      tx_valid[m] = 1'b0;
      push_en[m]  = 1'b0;
    end
    repeat (4) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      check_eq("reset_tx_ready", 32'(tx_ready[m]), 32'd1);
      check_eq("reset_rx_valid", 32'(rx_valid[m]), 32'd0);
      check_eq("reset_rx_data",  32'(rx_data[m]),  32'd0);
      check_eq("reset_miso",     32'(miso[m]),     32'd1);
      check_eq("reset_miso_oe",  32'(miso_oe[m]),  32'd0);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Mode 3, preloaded A5, master sends 3C.
    mosi_w[0] = 8'h3C;
    run_frame(3, 1, 0, 1'b1, 8'hA5);

    // Mode 0, nothing loaded: DEFAULT_TX returned with an underrun.
    mosi_w[0] = 8'h81;
    run_frame(0, 1, 0, 1'b0, 8'h00);

    // Mode 1, two words under one CS, second tx word queued during word 1.
    mosi_w[0] = 8'hC3; mosi_w[1] = 8'h5A;
    txw[0] = 8'h34; push_en[0] = 1'b1;
    run_frame(1, 2, 0, 1'b1, 8'h12);
    push_en[0] = 1'b0;

    // Mode 2, CS raised after 5 bits, then a clean F0 frame.
    mosi_w[0] = 8'hB7;
    run_frame(2, 1, 5, 1'b0, 8'h00);
    mosi_w[0] = 8'hF0;
    run_frame(2, 1, 0, 1'b0, 8'h00);

    // Mode 0, reset at bit 3 with a word waiting in the holding register.
    cur = 0;
    @(negedge clk);
    cs_n[0] = 1'b0;
    #80;
    xfer_word(0, 8'hE6, 3, 1'b1, 8'h99, dummy);
    check_eq("tx_ready_held", 32'(tx_ready[0]), 32'd0);
    rst = 1'b1;
    cs_n[0] = 1'b1;
    #10;
    check_eq("rst_mid_tx_ready", 32'(tx_ready[0]), 32'd1);
    check_eq("rst_mid_rx_valid", 32'(rx_valid[0]), 32'd0);
    check_eq("rst_mid_rx_data",  32'(rx_data[0]),  32'd0);
    check_eq("rst_mid_underrun", 32'(underrun[0]), 32'd0);
    check_eq("rst_mid_abort",    32'(abort_s[0]),  32'd0);
    check_eq("rst_mid_miso",     32'(miso[0]),     32'd1);
    check_eq("rst_mid_miso_oe",  32'(miso_oe[0]),  32'd0);
    rst = 1'b0;
    #50;
    mosi_w[0] = 8'h55;
    run_frame(0, 1, 0, 1'b1, 8'h3E);

    // Random frames in every mode.
    for (int m = 0; m < 4; m++) begin
      for (int f = 0; f < 4; f++) begin
        for (int w = 0; w < 4; w++) begin
          mosi_w[w]  = 8'($urandom);
          txw[w]     = 8'($urandom);
          push_en[w] = ($urandom_range(0, 1) == 1);
        end
        run_frame(m, int'($urandom_range(1, 3)), 0, ($urandom_range(0, 1) == 1), 8'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no completion required completion");
    $fatal(1, "timeout");
  end

endmodule
